// File: rtl/sfq_toggle_readout.sv
// Converts toggle-encoded SFQ clock/data lines into WORD_W-bit words behind a FWFT FIFO.
// Define SFQ_READOUT_PARITY_EN to store and present even parity per FIFO entry.
module sfq_toggle_readout #(
  parameter int WORD_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sfq_clk_in,
  input  logic              sfq_q_in,
  output logic [WORD_W-1:0] out_data,
  output logic              out_parity,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              clr_err,
  output logic              err_double,
  output logic              err_overflow
);
  localparam int BW = $clog2(WORD_W);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef SFQ_READOUT_PARITY_EN
  localparam int EW = WORD_W + 1;
`else
  localparam int EW = WORD_W;
`endif

  typedef enum logic {PRIME, RUN} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sc, sq;
  logic                   pc, pq, c_lvl, q_lvl, c_ev, d_ev;
  logic                   hit;
  logic [BW-1:0]          bcnt;
  logic [WORD_W-1:0]      shreg, nword, wdata;
  logic                   wvld;

  // Synchronizers are left unreset so they track the lines during reset; priming then sees settled levels.
  always_ff @(posedge clk) begin
    sc <= {sc[SYNC_STAGES-2:0], sfq_clk_in};
    sq <= {sq[SYNC_STAGES-2:0], sfq_q_in};
  end

  assign c_lvl = sc[SYNC_STAGES-1];
  assign q_lvl = sq[SYNC_STAGES-1];
  assign c_ev  = (state == RUN) && (c_lvl ^ pc);
  assign d_ev  = (state == RUN) && (q_lvl ^ pq);

  always_comb begin
    nword       = shreg;
    nword[bcnt] = hit | d_ev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PRIME;
      pc         <= 1'b0;
      pq         <= 1'b0;
      hit        <= 1'b0;
      bcnt       <= '0;
      shreg      <= '0;
      wvld       <= 1'b0;
      wdata      <= '0;
      err_double <= 1'b0;
    end else begin
      pc   <= c_lvl;
      pq   <= q_lvl;
      wvld <= 1'b0;
      if (clr_err) err_double <= 1'b0;
      case (state)
        PRIME: state <= RUN;
        RUN: begin
          if (c_ev) begin
            // A data event in the closing sample belongs to the slot being closed.
            if (d_ev && hit) err_double <= 1'b1;
            shreg <= nword;
            hit   <= 1'b0;
            if (bcnt == BW'(WORD_W - 1)) begin
              wvld  <= 1'b1;
              wdata <= nword;
              bcnt  <= '0;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end else if (d_ev) begin
            if (hit) err_double <= 1'b1;
            hit <= 1'b1;
          end
        end
        default: state <= PRIME;
      endcase
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] entry, head;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   cnt;
  logic          full, pop, wr_en;

`ifdef SFQ_READOUT_PARITY_EN
  assign entry      = {^wdata, wdata};
  assign out_parity = out_valid & head[WORD_W];
`else
  assign entry      = wdata;
  assign out_parity = 1'b0;
`endif

  assign head      = mem[rd_ptr];
  assign out_valid = (cnt != '0);
  assign out_data  = out_valid ? head[WORD_W-1:0] : '0;
  assign full      = (cnt == (AW+1)'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready;
  // When full, a same-edge pop frees the slot the write lands in.
  assign wr_en     = wvld & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      cnt          <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (clr_err) err_overflow <= 1'b0;
      if (wvld && !wr_en) err_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sfq_toggle_readout.sv
// Scoreboard bench for sfq_toggle_readout: stimulus queues expected words, a monitor checks pops.
module tb_sfq_toggle_readout;
  logic       clk = 1'b0;
  logic       rst, sfq_clk_in, sfq_q_in, out_ready, clr_err;
  logic [7:0] out_data;
  logic       out_parity, out_valid, err_double, err_overflow;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] sbq[$];

  sfq_toggle_readout #(.WORD_W(8), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sfq_clk_in(sfq_clk_in), .sfq_q_in(sfq_q_in),
    .out_data(out_data), .out_parity(out_parity), .out_valid(out_valid),
    .out_ready(out_ready), .clr_err(clr_err), .err_double(err_double),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic par(logic [7:0] w);
`ifdef SFQ_READOUT_PARITY_EN
    return ^w;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        chk("word", 32'(out_data), 32'(e));
        chk("parity", 32'(out_parity), 32'(par(e)));
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Data toggle (if any) lands inside the slot, then the clock toggle closes it.
  task automatic slot(logic b);
    if (b) begin sfq_q_in = ~sfq_q_in; cyc(4); end
    sfq_clk_in = ~sfq_clk_in;
    cyc(4);
  endtask

  task automatic send_word(logic [7:0] w);
    for (int i = 0; i < 8; i++) slot(w[i]);
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1'b1;
    while (sbq.size() != 0 && t < 300) begin cyc(1); t++; end
    cyc(2);
    chk("drain_remaining", 32'(sbq.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1; cyc(1); clr_err = 1'b0;
  endtask

  task automatic check_zero(string nm);
    chk({nm, "_data"}, 32'(out_data), 32'd0);
    chk({nm, "_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_parity"}, 32'(out_parity), 32'd0);
    chk({nm, "_errd"}, 32'(err_double), 32'd0);
    chk({nm, "_erro"}, 32'(err_overflow), 32'd0);
  endtask

  initial begin
    logic [7:0] w;
    rst = 1'b1; sfq_clk_in = 1'b1; sfq_q_in = 1'b1; out_ready = 1'b1; clr_err = 1'b0;
    cyc(3);
    check_zero("reset");
    rst = 1'b0;
    cyc(8);
    check_zero("primed");

    // 0x85 with word-latency check on the final clock toggle.
    sbq.push_back(8'h85);
    w = 8'h85;
    for (int i = 0; i < 7; i++) slot(w[i]);
    sfq_q_in = ~sfq_q_in; cyc(4);
    sfq_clk_in = ~sfq_clk_in;
    cyc(3);
    chk("latency_not_yet", 32'(out_valid), 32'd0);
    cyc(1);
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("basic_data", 32'(out_data), 32'h85);
    cyc(3);
    drain();

    // Data and clock toggled in the same sample: bit belongs to the closing slot.
    sbq.push_back(8'h01);
    sfq_q_in = ~sfq_q_in; sfq_clk_in = ~sfq_clk_in; cyc(4);
    for (int i = 1; i < 8; i++) slot(1'b0);
    chk("same_sample_errd", 32'(err_double), 32'd0);
    drain();

    // Two data pulses in one slot.
    sbq.push_back(8'h01);
    sfq_q_in = ~sfq_q_in; cyc(4);
    sfq_q_in = ~sfq_q_in; cyc(4);
    sfq_clk_in = ~sfq_clk_in; cyc(4);
    chk("double_errd", 32'(err_double), 32'd1);
    for (int i = 1; i < 8; i++) slot(1'b0);
    drain();
    pulse_clr();
    chk("double_cleared", 32'(err_double), 32'd0);

    // Overflow: five words with no consumer, the fifth is dropped.
    out_ready = 1'b0;
    sbq.push_back(8'h11); sbq.push_back(8'h22); sbq.push_back(8'h33); sbq.push_back(8'h44);
    send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
    chk("ovf_not_yet", 32'(err_overflow), 32'd0);
    send_word(8'h55);
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    chk("ovf_valid", 32'(out_valid), 32'd1);
    drain();
    pulse_clr();
    chk("ovf_cleared", 32'(err_overflow), 32'd0);

    // Full FIFO with a pop on the completing edge: no drop.
    out_ready = 1'b0;
    sbq.push_back(8'h66); sbq.push_back(8'h77); sbq.push_back(8'h88); sbq.push_back(8'h99);
    sbq.push_back(8'hAA);
    send_word(8'h66); send_word(8'h77); send_word(8'h88); send_word(8'h99);
    w = 8'hAA;
    for (int i = 0; i < 7; i++) slot(w[i]);
    sfq_q_in = ~sfq_q_in; cyc(4);
    sfq_clk_in = ~sfq_clk_in;
    cyc(3);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    cyc(3);
    chk("pushpop_no_ovf", 32'(err_overflow), 32'd0);
    drain();

    // Mid-word reset discards FIFO content, partial word and flags.
    out_ready = 1'b0;
    send_word(8'hFF);
    slot(1'b1); slot(1'b0);
    sfq_q_in = ~sfq_q_in; cyc(4);
    sfq_q_in = ~sfq_q_in; cyc(4);
    sfq_clk_in = ~sfq_clk_in; cyc(4);
    slot(1'b1); slot(1'b0);
    chk("pre_reset_errd", 32'(err_double), 32'd1);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    cyc(3);
    check_zero("midreset");
    rst = 1'b0;
    cyc(4);
    out_ready = 1'b1;
    sbq.push_back(8'h3C);
    send_word(8'h3C);
    drain();
    chk("final_errd", 32'(err_double), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
